// File: rtl/output_uart.sv
// output_uart: buffers 16-bit cluster output words and prints each one as lowercase hex text plus LF on an 8N1 UART line.
// Latency: word strobed in cycle N with the FSM idle and the FIFO empty -> LOAD in N+1, start bit from N+2.
// Backpressure: none upstream; a strobe that finds the FIFO full with no same-cycle pop is dropped and sets sticky overflow.
// Build option: define OUTPUT_UART_PREFIX_EN to precede every word with the text "output " (12 characters per word).

// Small synchronous FIFO with extra-bit pointers; the caller only writes when not full (or popping) and only reads when not empty.
module output_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;

    // Pointers carry one extra bit so full and empty are distinguishable; the difference wraps naturally.
    assign count  = wr_ptr - rd_ptr;
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign rd_dat = mem[rd_ptr[PTR_W-1:0]];

    // Pointer advance on accepted write and on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage; when full and popping, the write lands in the slot being read, which is safe because the read uses the old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_dat;
        end
    end
endmodule

module output_uart #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] output_val,
    input  logic        output_enable,
    output logic        uart_tx,
    output logic        fifo_full,
    output logic        overflow,
    output logic        busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

`ifdef OUTPUT_UART_PREFIX_EN
    localparam int NUM_CHARS = 12;
    localparam int HEX_BASE  = 7;
`else
    localparam int NUM_CHARS = 5;
    localparam int HEX_BASE  = 0;
`endif

    localparam logic [3:0]        HEX_POS0  = 4'(HEX_BASE);
    localparam logic [3:0]        LAST_CHAR = 4'(NUM_CHARS - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [1:0]        rst_sync;
    logic              rst_n;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       word_reg;
    logic [3:0]        char_idx;
    logic [2:0]        bit_idx;
    logic [BAUD_W-1:0] baud_cnt;

    logic              fifo_empty;
    logic [15:0]       fifo_rd_dat;
    logic              pop;
    logic              wr_accept;

    logic              baud_done;
    logic              last_char;
    logic [3:0]        nibble;
    logic              is_hex;
    logic [7:0]        hex_ascii;
    logic [7:0]        text_char;
    logic [7:0]        cur_char;

    // Reset asserts asynchronously and releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // The head word is popped in the single LOAD cycle; a strobe in that cycle is accepted even when full.
    assign pop       = (state == S_LOAD);
    assign wr_accept = output_enable & (~fifo_full | pop);

    output_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_accept),
        .wr_dat (output_val),
        .rd_en  (pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sticky drop flag: set the cycle after a strobe is refused, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (output_enable && !wr_accept) begin
            overflow <= 1'b1;
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign last_char = (char_idx == LAST_CHAR);
    assign busy      = (state != S_IDLE) | ~fifo_empty;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: IDLE also reacts to the word being written this cycle so LOAD follows the strobe directly.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty || wr_accept) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_START;
            end
            S_START: begin
                if (baud_done) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done && bit_idx == 3'd7) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    if (!last_char) begin
                        state_nxt = S_START;
                    end else if (!fifo_empty) begin
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Baud and bit counters restart on every state entry; the baud counter also wraps at each bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
        end else begin
            if (state_nxt != state || baud_done || state == S_IDLE || state == S_LOAD) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            if (state_nxt != state) begin
                bit_idx <= 3'd0;
            end else if (state == S_DATA && baud_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Word register and character index: captured at LOAD, index steps at the end of each non-final stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= 16'h0000;
            char_idx <= 4'd0;
        end else begin
            if (pop) begin
                word_reg <= fifo_rd_dat;
                char_idx <= 4'd0;
            end else if (state == S_STOP && baud_done && !last_char) begin
                char_idx <= char_idx + 4'd1;
            end
        end
    end

    // Hex digit selection: four nibbles MSB-first starting at HEX_POS0.
    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        case (char_idx)
            HEX_POS0: begin
                is_hex = 1'b1;
                nibble = word_reg[15:12];
            end
            HEX_POS0 + 4'd1: begin
                is_hex = 1'b1;
                nibble = word_reg[11:8];
            end
            HEX_POS0 + 4'd2: begin
                is_hex = 1'b1;
                nibble = word_reg[7:4];
            end
            HEX_POS0 + 4'd3: begin
                is_hex = 1'b1;
                nibble = word_reg[3:0];
            end
            default: begin
                is_hex = 1'b0;
                nibble = 4'h0;
            end
        endcase
    end

    // 0-9 map to '0'-'9'; 10-15 map to 'a'-'f' (0x57 + 10 = 0x61).
    assign hex_ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});

`ifdef OUTPUT_UART_PREFIX_EN
    // Fixed text: "output " prefix ahead of the digits, line feed after them.
    always_comb begin
        case (char_idx)
            4'd0:    text_char = 8'h6F;
            4'd1:    text_char = 8'h75;
            4'd2:    text_char = 8'h74;
            4'd3:    text_char = 8'h70;
            4'd4:    text_char = 8'h75;
            4'd5:    text_char = 8'h74;
            4'd6:    text_char = 8'h20;
            default: text_char = 8'h0A;
        endcase
    end
`else
    // Only non-digit character is the trailing line feed.
    assign text_char = 8'h0A;
`endif

    assign cur_char = is_hex ? hex_ascii : text_char;

    // Line driver: low for start, character bits LSB-first in DATA, high everywhere else (idle, LOAD, stop).
    always_comb begin
        case (state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = cur_char[bit_idx];
            default: uart_tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_output_uart.sv
`timescale 1ns/1ps
module tb_output_uart;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
`ifdef OUTPUT_UART_PREFIX_EN
    localparam int NCHARS = 12;
`else
    localparam int NCHARS = 5;
`endif
    localparam int WORD_CYCLES = NCHARS * 10 * CPB + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] output_val = 16'h0000;
    logic        output_enable = 1'b0;
    logic        uart_tx;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    string hex_digits = "0123456789abcdef";
    string prefix_str = "output ";

    output_uart #(
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .output_val    (output_val),
        .output_enable (output_enable),
        .uart_tx       (uart_tx),
        .fifo_full     (fifo_full),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected text for one word pushed onto the scoreboard.
    task automatic push_word(input logic [15:0] w);
`ifdef OUTPUT_UART_PREFIX_EN
        for (int i = 0; i < 7; i++) exp_q.push_back(8'(prefix_str.getc(i)));
`endif
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(hex_digits.getc(int'(w[i*4 +: 4]))));
        exp_q.push_back(8'h0A);
    endtask

    task automatic strobe(input logic [15:0] v);
        output_val    = v;
        output_enable = 1'b1;
        @(posedge clk); #1;
        output_enable = 1'b0;
    endtask

    task automatic goto_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        output_enable = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.delete();
        start_q.delete();
    endtask

    task automatic wait_idle(input string name, output int idle_cyc);
        int n;
        n = 0;
        idle_cyc = -1;
        while (n < 20000) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle_cyc = cyc;
                break;
            end
            n++;
        end
        tests_run++;
        if (idle_cyc < 0) begin
            tests_failed++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        @(posedge clk); #1;
    endtask

    // UART receiver: samples mid-bit on the falling clock edge and checks each character against the scoreboard.
    task automatic uart_monitor();
        logic       active;
        int         cnt;
        logic [7:0] sh;
        logic [7:0] exp_c;
        active = 1'b0;
        cnt = 0;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (uart_tx === 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt >= CPB + CPB/2 && cnt < 9*CPB && ((cnt - CPB/2) % CPB) == 0) begin
                    sh = {uart_tx, sh[7:1]};
                end else if (cnt == 9*CPB + CPB/2) begin
                    active = 1'b0;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL uart_char: got 0x%02h with nothing expected", sh);
                    end else begin
                        exp_c = exp_q.pop_front();
                        if (sh !== exp_c || uart_tx !== 1'b1) begin
                            tests_failed++;
                            $display("FAIL uart_char: got 0x%02h stop=%b, expected 0x%02h stop=1", sh, uart_tx, exp_c);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        output_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (uart_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_uart_tx: got %b, expected 1", uart_tx); end
        tests_run++;
        if (fifo_full !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo_full: got %b, expected 0", fifo_full); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_after_release: busy=%b tx=%b, expected busy=0 tx=1", busy, uart_tx);
        end
    endtask

    task automatic test_single_word();
        int n0, li, first;
        do_reset();
        n0 = cyc;
        push_word(16'h12AB);
        strobe(16'h12AB);
        tests_run++;
        if (busy !== 1'b1 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_cycle: busy=%b tx=%b, expected busy=1 tx=1", busy, uart_tx);
        end
        wait_idle("single", li);
        first = (start_q.size() > 0) ? start_q[0] : -1;
        tests_run++;
        if (first != n0 + 2) begin tests_failed++; $display("FAIL start_latency: start at %0d, expected %0d", first, n0 + 2); end
        tests_run++;
        if (li != n0 + 1 + WORD_CYCLES) begin tests_failed++; $display("FAIL busy_fall: at %0d, expected %0d", li, n0 + 1 + WORD_CYCLES); end
        tests_run++;
        if (start_q.size() != NCHARS) begin tests_failed++; $display("FAIL frame_count: got %0d, expected %0d", start_q.size(), NCHARS); end
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL single_drained: %0d chars missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int n0, li, gap;
        do_reset();
        n0 = cyc;
        push_word(16'hF09C);
        push_word(16'h0000);
        strobe(16'hF09C);
        strobe(16'h0000);
        wait_idle("b2b", li);
        gap = (start_q.size() > NCHARS) ? (start_q[NCHARS] - start_q[0]) : -1;
        tests_run++;
        if (gap != WORD_CYCLES) begin tests_failed++; $display("FAIL b2b_gap: word spacing %0d, expected %0d", gap, WORD_CYCLES); end
        tests_run++;
        if (li != n0 + 1 + 2 * WORD_CYCLES) begin tests_failed++; $display("FAIL b2b_busy_fall: at %0d, expected %0d", li, n0 + 1 + 2 * WORD_CYCLES); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_overflow: got %b, expected 0", overflow); end
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_drained: %0d chars missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_digits();
        int li;
        do_reset();
        push_word(16'h3456);
        push_word(16'h7DE8);
        strobe(16'h3456);
        strobe(16'h7DE8);
        wait_idle("digits", li);
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL digits_drained: %0d chars missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        int li;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) push_word(16'(i));
            strobe(16'(i));
            if (i == 7) begin
                tests_run++;
                if (fifo_full !== 1'b0) begin tests_failed++; $display("FAIL full_after_8: got %b, expected 0", fifo_full); end
            end
            if (i == 8) begin
                tests_run++;
                if (fifo_full !== 1'b1) begin tests_failed++; $display("FAIL full_after_9: got %b, expected 1", fifo_full); end
                tests_run++;
                if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_before_drop: got %b, expected 0", overflow); end
            end
        end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_after_drop: got %b, expected 1", overflow); end
        wait_idle("overflow", li);
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ovf_drained: %0d chars missing, expected 0", exp_q.size()); end
        tests_run++;
        if (overflow !== 1'b1 || fifo_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_sticky: overflow=%b full=%b, expected overflow=1 full=0", overflow, fifo_full);
        end
    endtask

    task automatic test_pop_when_full();
        int n0, li, target;
        do_reset();
        n0 = cyc;
        for (int i = 0; i < 9; i++) begin
            push_word(16'hA000 + 16'(i));
            strobe(16'hA000 + 16'(i));
        end
        target = n0 + 1 + WORD_CYCLES;
        goto_cycle(target - 1);
        tests_run++;
        if (fifo_full !== 1'b1) begin tests_failed++; $display("FAIL full_before_pop: got %b, expected 1", fifo_full); end
        goto_cycle(target);
        push_word(16'hA009);
        strobe(16'hA009);
        tests_run++;
        if (fifo_full !== 1'b1) begin tests_failed++; $display("FAIL full_after_pop_write: got %b, expected 1", fifo_full); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pop_write_overflow: got %b, expected 0", overflow); end
        wait_idle("popfull", li);
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL popfull_drained: %0d chars missing, expected 0", exp_q.size()); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL popfull_overflow_end: got %b, expected 0", overflow); end
    endtask

    task automatic test_reset_mid_char();
        int n0, n1, li, first, target;
        logic exp_bit;
        do_reset();
        n0 = cyc;
        push_word(16'h1234);
        strobe(16'h1234);
        for (int i = 0; i < 9; i++) strobe(16'h5000 + 16'(i));
        target = n0 + 2 + 10 * CPB + CPB + 2 * CPB + 1;
        goto_cycle(target);
        tests_run++;
        if (exp_q.size() != NCHARS - 1) begin tests_failed++; $display("FAIL mid_first_char: %0d chars pending, expected %0d", exp_q.size(), NCHARS - 1); end
        exp_bit = (exp_q.size() > 0) ? exp_q[0][2] : 1'b1;
        tests_run++;
        if (uart_tx !== exp_bit || busy !== 1'b1 || fifo_full !== 1'b1 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_data_state: tx=%b busy=%b full=%b ovf=%b, expected tx=%b busy=1 full=1 ovf=1", uart_tx, busy, fifo_full, overflow, exp_bit);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: tx=%b busy=%b full=%b ovf=%b, expected tx=1 busy=0 full=0 ovf=0", uart_tx, busy, fifo_full, overflow);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.delete();
        start_q.delete();
        n1 = cyc;
        push_word(16'h0001);
        strobe(16'h0001);
        wait_idle("post_reset", li);
        first = (start_q.size() > 0) ? start_q[0] : -1;
        tests_run++;
        if (first != n1 + 2) begin tests_failed++; $display("FAIL post_reset_latency: start at %0d, expected %0d", first, n1 + 2); end
        tests_run++;
        if (li != n1 + 1 + WORD_CYCLES) begin tests_failed++; $display("FAIL post_reset_busy_fall: at %0d, expected %0d", li, n1 + 1 + WORD_CYCLES); end
        tests_run++;
        if (exp_q.size() != 0 || start_q.size() != NCHARS) begin
            tests_failed++;
            $display("FAIL post_reset_text: %0d chars missing, %0d frames, expected 0 and %0d", exp_q.size(), start_q.size(), NCHARS);
        end
    endtask

    task automatic test_beef_word();
        int n0, li;
        do_reset();
        n0 = cyc;
        push_word(16'hBEEF);
        strobe(16'hBEEF);
        wait_idle("beef", li);
        tests_run++;
        if (li != n0 + 1 + WORD_CYCLES) begin tests_failed++; $display("FAIL beef_duration: busy fell at %0d, expected %0d", li, n0 + 1 + WORD_CYCLES); end
        tests_run++;
        if (exp_q.size() != 0 || start_q.size() != NCHARS) begin
            tests_failed++;
            $display("FAIL beef_text: %0d chars missing, %0d frames, expected 0 and %0d", exp_q.size(), start_q.size(), NCHARS);
        end
    endtask

    initial begin
        fork
            uart_monitor();
        join_none
        test_reset();
        test_single_word();
        test_back_to_back();
        test_digits();
        test_overflow();
        test_pop_when_full();
        test_reset_mid_char();
        test_beef_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/output_uart.md
Name: output_uart

Overview:
- Sits directly downstream of the cluster top level and consumes its output_val/output_enable stream of 16-bit output words.
- Buffers words in a small FIFO.
- Serializes each word as ASCII text on an 8N1 UART transmit line, matching the simulation console format: four lowercase hex digits MSB-first, then line feed.
- Lets hardware builds report core output without a simulator.

Parameters:
FIFO_DEPTH, 8, number of buffered 16-bit words; power of two, >= 2
CLKS_PER_BIT, 16, clk cycles per UART bit; >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
output_val  input  16  output word from cluster
output_enable  input  1  output_val valid this cycle (single-cycle strobe, no backpressure)
uart_tx  output  1  serial line, idle high
fifo_full  output  1  FIFO holds FIFO_DEPTH words
overflow  output  1  sticky: at least one word dropped since reset
busy  output  1  FIFO non-empty or character in progress

Behaviour:
- Reset (async assert, sync deassert via flop): FIFO empty; state IDLE.
  - uart_tx=1, fifo_full=0, overflow=0, busy=0; all immediately on reset_n low.
- Write: on output_enable, word accepted if count < FIFO_DEPTH, or if a pop occurs the same cycle.
  - Otherwise dropped, and overflow set to 1 next cycle.
  - overflow clears only on reset.
- Pointers: log2(FIFO_DEPTH)+1 bits; wrap naturally. count = wr_ptr - rd_ptr.
- Transmit FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE -> LOAD when FIFO non-empty.
  - LOAD: pop head into 16-bit word register, char index=0. One cycle, uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB-first, each CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then next char -> START; after the last char -> IDLE, or LOAD if FIFO non-empty.
- Character generation: char index 0..3 selects nibble [15:12],[11:8],[7:4],[3:0].
  - Nibble 0-9 -> 0x30-0x39; nibble 10-15 -> 0x61-0x66.
  - Index 4 -> 0x0A.
- Latency: word strobed at cycle N with FSM idle and FIFO empty → in FIFO at N+1, LOAD at N+1, start bit driven from N+2.
- Per word: 5 chars x 10 bits x CLKS_PER_BIT cycles + 1 LOAD cycle.
- busy = (state != IDLE) | (count != 0).
- Bit counter and baud counter reset at every state entry; no fractional baud.
- Reset mid-character: line returns high immediately; the partial character is abandoned and no resume occurs.

Optional Feature:
- OUTPUT_UART_PREFIX_EN defined: each word is preceded by the 7-character prefix "output " (0x6F 0x75 0x74 0x70 0x75 0x74 0x20).
  - 12 chars per word.
  - Char index range becomes 0..11.
- Undefined: 5 chars per word as above; no prefix ROM synthesized.

Test Plan:
1. CLKS_PER_BIT=4, single strobe output_val=0x12AB -> uart_tx decodes 0x31,0x32,0x61,0x62,0x0A.
   - Start bit begins 2 cycles after strobe.
   - busy falls exactly 1+200 cycles after LOAD.
2. Value 0xF09C then 0x0000 back-to-back -> "f09c\n0000\n", no idle gap between words (STOP -> LOAD -> START), overflow=0.
3. FIFO_DEPTH=8, 10 consecutive strobes 0x0000..0x0009 from empty:
   - word 0 popped at cycle 1; words 1..8 buffered; fifo_full=1 after the 9th strobe.
   - 0x0009 dropped, overflow=1.
   - Serial output is 0000..0008 only.
4. Strobe arriving in the same cycle as a pop with FIFO full -> accepted, count stays FIFO_DEPTH, overflow remains 0.
5. Assert reset_n low mid-DATA of second character -> uart_tx=1, busy=0, fifo_full=0, overflow=0 same cycle. After release, a new strobe 0x0001 transmits cleanly "0001\n".
6. With OUTPUT_UART_PREFIX_EN, output_val=0xBEEF -> "output beef\n" (12 chars, 120 bit times).
